// File: rtl/ipv4_parser.sv
// IPv4 header parser: validates the header of each de-encapsulated Ethernet payload,
// strips header and padding, and forwards the IP payload with one eof/err strobe per frame.
module ipv4_parser #(
   parameter logic [7:0]  PROTOCOL  = 8'd17,
   parameter logic [31:0] LOCAL_IP  = 32'hC0A8010A,
   parameter bit          CHECK_DST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  eth_data_in,
   input  logic        eth_byte_valid,
   input  logic        eth_eof,
   input  logic        eth_err,
   output logic [7:0]  ip_data_out,
   output logic        ip_byte_valid,
   output logic        ip_eof,
   output logic        ip_err,
   output logic [31:0] ip_src_addr,
   output logic [15:0] ip_payload_len,
   output logic [1:0]  dbg_state
);

   // Handshake: valid-only streams, no ready. A byte with eth_byte_valid high is consumed
   // in that cycle; ip_byte_valid marks ip_data_out for exactly one cycle and cannot stall.
   typedef enum logic [1:0] {
      S_HDR     = 2'd0,
      S_PAYLOAD = 2'd1,
      S_PAD     = 2'd2,
      S_DROP    = 2'd3
   } state_t;

   state_t      state;
   state_t      nxt_state;
   logic [5:0]  byte_cnt;
   logic [5:0]  hdr_len;
   logic [3:0]  ihl;
   logic [15:0] total_len;
   logic [15:0] csum;
   logic [15:0] csum_add;
   logic [16:0] word_sum;
   logic [15:0] rem;
   logic [15:0] rem_calc;
   logic [7:0]  hi_byte;
   logic [31:0] src_tmp;
   logic        err;
   logic        field_fail;
   logic        hdr_last;
   logic        hdr_ok;
   logic        err_set;
   logic        truncated;

   assign dbg_state = state;

   always_comb begin
      hdr_len  = {ihl, 2'b00};
      word_sum = {1'b0, csum} + {1'b0, hi_byte, eth_data_in};
      csum_add = word_sum[15:0] + {15'd0, word_sum[16]};
      rem_calc = total_len - {10'd0, hdr_len};
      hdr_last = (byte_cnt != 6'd0) && (byte_cnt == hdr_len - 6'd1);

      // hi_byte holds the preceding even-offset byte, so 16-bit fields are checked on their low byte
      field_fail = 1'b0;
      case (byte_cnt)
         6'd0:    field_fail = (eth_data_in[7:4] != 4'd4) || (eth_data_in[3:0] < 4'd5);
         6'd3:    field_fail = {hi_byte, eth_data_in} < {10'd0, hdr_len};
         6'd7:    field_fail = hi_byte[5] || (hi_byte[4:0] != 5'd0) || (eth_data_in != 8'd0);
         6'd9:    field_fail = eth_data_in != PROTOCOL;
         6'd16:   field_fail = CHECK_DST && (eth_data_in != LOCAL_IP[31:24]);
         6'd17:   field_fail = CHECK_DST && (eth_data_in != LOCAL_IP[23:16]);
         6'd18:   field_fail = CHECK_DST && (eth_data_in != LOCAL_IP[15:8]);
         6'd19:   field_fail = CHECK_DST && (eth_data_in != LOCAL_IP[7:0]);
         default: field_fail = 1'b0;
      endcase

      hdr_ok    = hdr_last && !field_fail && (csum_add == 16'hFFFF);
      nxt_state = state;
      err_set   = 1'b0;
      if (eth_byte_valid) begin
         case (state)
            S_HDR: begin
               if (field_fail || (hdr_last && !hdr_ok)) begin
                  nxt_state = S_DROP;
                  err_set   = 1'b1;
               end else if (hdr_ok) begin
                  nxt_state = (rem_calc == 16'd0) ? S_PAD : S_PAYLOAD;
               end
            end
            S_PAYLOAD: if (rem == 16'd1) nxt_state = S_PAD;
            default:   nxt_state = state;
         endcase
      end
      // Evaluated after this cycle's byte: still in HDR or PAYLOAD means the frame ended early
      truncated = (nxt_state == S_HDR) || (nxt_state == S_PAYLOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_HDR;
         byte_cnt       <= 6'd0;
         ihl            <= 4'd0;
         total_len      <= 16'd0;
         csum           <= 16'd0;
         hi_byte        <= 8'd0;
         src_tmp        <= 32'd0;
         rem            <= 16'd0;
         err            <= 1'b0;
         ip_data_out    <= 8'd0;
         ip_byte_valid  <= 1'b0;
         ip_eof         <= 1'b0;
         ip_err         <= 1'b0;
         ip_src_addr    <= 32'd0;
         ip_payload_len <= 16'd0;
      end else begin
         ip_byte_valid <= 1'b0;
         ip_eof        <= 1'b0;
         ip_err        <= 1'b0;
         if (eth_byte_valid) begin
            case (state)
               S_HDR: begin
                  byte_cnt <= byte_cnt + 6'd1;
                  if (!byte_cnt[0]) hi_byte <= eth_data_in;
                  else              csum    <= csum_add;
                  if (byte_cnt == 6'd0) ihl <= eth_data_in[3:0];
                  if (byte_cnt == 6'd2) total_len[15:8] <= eth_data_in;
                  if (byte_cnt == 6'd3) total_len[7:0]  <= eth_data_in;
                  if ((byte_cnt >= 6'd12) && (byte_cnt <= 6'd15))
                     src_tmp <= {src_tmp[23:0], eth_data_in};
                  if (hdr_ok) begin
                     ip_src_addr    <= src_tmp;
                     ip_payload_len <= rem_calc;
                     rem            <= rem_calc;
                  end
               end
               S_PAYLOAD: begin
                  ip_data_out   <= eth_data_in;
                  ip_byte_valid <= 1'b1;
                  rem           <= rem - 16'd1;
               end
               default: ;
            endcase
         end
         state <= nxt_state;
         if (err_set) err <= 1'b1;
         if (eth_eof) begin
            ip_eof   <= 1'b1;
            ip_err   <= err | err_set | eth_err | truncated;
            state    <= S_HDR;
            byte_cnt <= 6'd0;
            csum     <= 16'd0;
            err      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ipv4_parser.sv
// Bench for ipv4_parser: two instances (dst check on/off) driven with the same frames,
// compared against a whole-frame reference model of the IPv4 acceptance rules.
module tb_ipv4_parser;

   localparam logic [31:0] LOCAL_IP = 32'hC0A8010A;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  eth_data_in = 8'd0;
   logic        eth_byte_valid = 1'b0;
   logic        eth_eof = 1'b0;
   logic        eth_err = 1'b0;

   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid, a_eof, b_eof, a_err, b_err;
   logic [31:0] a_src, b_src;
   logic [15:0] a_len, b_len;
   logic [1:0]  a_dbg, b_dbg;

   ipv4_parser dut_a (
      .clk(clk), .rst_n(rst_n), .eth_data_in(eth_data_in), .eth_byte_valid(eth_byte_valid),
      .eth_eof(eth_eof), .eth_err(eth_err), .ip_data_out(a_data), .ip_byte_valid(a_valid),
      .ip_eof(a_eof), .ip_err(a_err), .ip_src_addr(a_src), .ip_payload_len(a_len),
      .dbg_state(a_dbg)
   );

   ipv4_parser #(.CHECK_DST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .eth_data_in(eth_data_in), .eth_byte_valid(eth_byte_valid),
      .eth_eof(eth_eof), .eth_err(eth_err), .ip_data_out(b_data), .ip_byte_valid(b_valid),
      .ip_eof(b_eof), .ip_err(b_err), .ip_src_addr(b_src), .ip_payload_len(b_len),
      .dbg_state(b_dbg)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitors
   logic [7:0] a_got[$];
   logic [7:0] b_got[$];
   int   a_eofs = 0, b_eofs = 0, a_err_noeof = 0, b_err_noeof = 0;
   logic a_err_seen = 1'b0, b_err_seen = 1'b0;

   always @(negedge clk) begin
      if (a_valid) a_got.push_back(a_data);
      if (b_valid) b_got.push_back(b_data);
      if (a_eof) begin a_eofs++; a_err_seen = a_err; end
      if (b_eof) begin b_eofs++; b_err_seen = b_err; end
      if (a_err && !a_eof) a_err_noeof++;
      if (b_err && !b_eof) b_err_noeof++;
   end

   // Reference model over the whole frame as it was sent
   logic [7:0]  frame_q[$];
   logic [7:0]  exp_q[$];
   logic        exp_err;
   logic        exp_hdr_ok;
   logic [15:0] exp_len;
   logic [31:0] exp_src;

   function automatic logic [15:0] ones_sum(input int hl);
      int unsigned s;
      s = 0;
      for (int i = 0; i < hl / 2; i++) s += {16'd0, frame_q[2*i], frame_q[2*i+1]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return s[15:0];
   endfunction

   function automatic void model(input bit chk_dst, input bit eerr);
      int n, hl, tl, rem, avail;
      bit bad;
      n = frame_q.size();
      exp_q.delete();
      exp_hdr_ok = 1'b0;
      bad = 1'b0;
      if (n == 0) begin exp_err = 1'b1; return; end
      hl = 4 * int'(frame_q[0][3:0]);
      tl = 0;
      if (frame_q[0][7:4] != 4'd4 || hl < 20 || n < hl) bad = 1'b1;
      else begin
         tl = int'({frame_q[2], frame_q[3]});
         if (tl < hl) bad = 1'b1;
         if (frame_q[6][5] || frame_q[6][4:0] != 5'd0 || frame_q[7] != 8'd0) bad = 1'b1;
         if (frame_q[9] != 8'd17) bad = 1'b1;
         if (chk_dst && {frame_q[16], frame_q[17], frame_q[18], frame_q[19]} != LOCAL_IP) bad = 1'b1;
         if (ones_sum(hl) != 16'hFFFF) bad = 1'b1;
      end
      if (bad) begin exp_err = 1'b1; return; end
      exp_hdr_ok = 1'b1;
      rem = tl - hl;
      avail = n - hl;
      exp_len = 16'(rem);
      exp_src = {frame_q[12], frame_q[13], frame_q[14], frame_q[15]};
      for (int i = 0; i < rem && i < avail; i++) exp_q.push_back(frame_q[hl + i]);
      exp_err = eerr || (avail < rem);
   endfunction

   task automatic set_csum(input int hl, input bit bad);
      logic [15:0] cs;
      frame_q[10] = 8'd0;
      frame_q[11] = 8'd0;
      cs = ~ones_sum(hl);
      frame_q[10] = cs[15:8] ^ {7'd0, bad};
      frame_q[11] = cs[7:0];
   endtask

   task automatic build(input int ihl, input int plen, input int pad_to, input logic [7:0] proto,
                        input logic [31:0] dst, input logic [7:0] flags, input bit csum_bad,
                        input bit ramp, input logic [7:0] base);
      int hl;
      logic [15:0] tl;
      hl = ihl * 4;
      tl = 16'(hl + plen);
      frame_q.delete();
      frame_q.push_back({4'd4, 4'(ihl)});
      frame_q.push_back(8'h00);
      frame_q.push_back(tl[15:8]);
      frame_q.push_back(tl[7:0]);
      frame_q.push_back(8'($urandom));
      frame_q.push_back(8'($urandom));
      frame_q.push_back(flags);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h40);
      frame_q.push_back(proto);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'h00);
      frame_q.push_back(8'hC0);
      frame_q.push_back(8'hA8);
      frame_q.push_back(8'h01);
      frame_q.push_back(8'($urandom_range(1, 254)));
      frame_q.push_back(dst[31:24]);
      frame_q.push_back(dst[23:16]);
      frame_q.push_back(dst[15:8]);
      frame_q.push_back(dst[7:0]);
      for (int i = 20; i < hl; i++) frame_q.push_back(8'($urandom));
      set_csum(hl, csum_bad);
      for (int i = 0; i < plen; i++) frame_q.push_back(ramp ? base + 8'(i) : 8'($urandom));
      while (frame_q.size() < pad_to) frame_q.push_back(8'($urandom));
   endtask

   task automatic send(input bit eerr, input bit eof_sep, input bit do_eof);
      int n;
      n = frame_q.size();
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0;
         end
         @(posedge clk); #1;
         eth_byte_valid = 1'b1;
         eth_data_in    = frame_q[i];
         eth_eof        = do_eof && !eof_sep && (i == n - 1);
         eth_err        = eerr && eth_eof;
      end
      if (do_eof && (eof_sep || n == 0)) begin
         @(posedge clk); #1;
         eth_byte_valid = 1'b0; eth_data_in = 8'd0; eth_eof = 1'b1; eth_err = eerr;
      end
      @(posedge clk); #1;
      eth_byte_valid = 1'b0; eth_eof = 1'b0; eth_err = 1'b0; eth_data_in = 8'd0;
   endtask

   task automatic check_dut(input string tag, input bit which, input bit eerr, input int eofs);
      logic [7:0]  g[$];
      logic        err_seen;
      logic [15:0] len;
      logic [31:0] src;
      if (which) begin g = b_got; err_seen = b_err_seen; len = b_len; src = b_src; end
      else       begin g = a_got; err_seen = a_err_seen; len = a_len; src = a_src; end
      model(!which, eerr);
      check({tag, " eof_count"}, 64'(eofs), 64'd1);
      check({tag, " err"}, 64'(err_seen), 64'(exp_err));
      check({tag, " nbytes"}, 64'(g.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < g.size(); i++)
         check($sformatf("%s byte%0d", tag, i), 64'(g[i]), 64'(exp_q[i]));
      if (exp_hdr_ok) begin
         check({tag, " payload_len"}, 64'(len), 64'(exp_len));
         check({tag, " src_addr"}, 64'(src), 64'(exp_src));
      end
   endtask

   task automatic run(input string tag, input bit eerr, input int cut, input bit eof_sep);
      int a0, b0;
      a0 = a_eofs;
      b0 = b_eofs;
      if (cut >= 0) while (frame_q.size() > cut) void'(frame_q.pop_back());
      a_got.delete();
      b_got.delete();
      send(eerr, eof_sep, 1'b1);
      for (int k = 0; k < 10 && !(a_eofs > a0 && b_eofs > b0); k++) @(negedge clk);
      @(negedge clk);
      check_dut({tag, "/a"}, 1'b0, eerr, a_eofs - a0);
      check_dut({tag, "/b"}, 1'b1, eerr, b_eofs - b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " a_data"},  64'(a_data),  64'd0);
      check({tag, " a_valid"}, 64'(a_valid), 64'd0);
      check({tag, " a_eof"},   64'(a_eof),   64'd0);
      check({tag, " a_err"},   64'(a_err),   64'd0);
      check({tag, " a_src"},   64'(a_src),   64'd0);
      check({tag, " a_len"},   64'(a_len),   64'd0);
      check({tag, " b_valid"}, 64'(b_valid), 64'd0);
      check({tag, " b_len"},   64'(b_len),   64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ihl, plen, kind, cut, a0, b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Good frame, 16-byte ramp payload, eof on last byte
      build(5, 16, 0, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'h00);
      run("t1_good", 1'b0, -1, 1'b0);
      // Checksum corrupted
      build(5, 16, 0, 8'd17, LOCAL_IP, 8'h00, 1'b1, 1'b1, 8'h00);
      run("t2_csum", 1'b0, -1, 1'b0);
      // Short payload with Ethernet padding to 46 bytes
      build(5, 8, 46, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'hAA);
      run("t3_pad", 1'b0, -1, 1'b1);
      // Wrong protocol, then wrong destination (accepted by the no-dst-check instance)
      build(5, 16, 0, 8'd6, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'h00);
      run("t4_proto", 1'b0, -1, 1'b0);
      build(5, 16, 0, 8'd17, 32'hC0A8010B, 8'h00, 1'b0, 1'b1, 8'h00);
      run("t4_dst", 1'b0, -1, 1'b0);
      // Early eof after 10 payload bytes, then eth_err on a complete frame
      build(5, 16, 0, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'h00);
      run("t5_trunc", 1'b0, 30, 1'b1);
      build(5, 16, 0, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'h00);
      run("t5_etherr", 1'b1, -1, 1'b0);
      // Zero-length payload: header ends together with eof
      build(5, 0, 0, 8'd17, LOCAL_IP, 8'h40, 1'b0, 1'b0, 8'h00);
      run("empty_payload", 1'b0, -1, 1'b0);
      // IHL 6 with options covered by the checksum
      build(6, 12, 0, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b0, 8'h00);
      run("t6_opts", 1'b0, -1, 1'b0);

      // Randomized frames with assorted header faults, truncation and eth_err
      for (int t = 0; t < 12; t++) begin
         ihl  = $urandom_range(5, 7);
         plen = $urandom_range(0, 30);
         kind = $urandom_range(0, 10);
         build(ihl, plen, ($urandom_range(0, 1) == 1) ? 46 : 0, 8'd17, LOCAL_IP, 8'h40,
               1'b0, 1'b0, 8'h00);
         case (kind)
            1: begin frame_q[9] = 8'd6; set_csum(ihl * 4, 1'b0); end
            2: begin frame_q[19] = frame_q[19] ^ 8'h01; set_csum(ihl * 4, 1'b0); end
            3: frame_q[11] = frame_q[11] ^ 8'h80;
            4: begin frame_q[6] = 8'h20; set_csum(ihl * 4, 1'b0); end
            5: begin frame_q[7] = 8'h08; set_csum(ihl * 4, 1'b0); end
            6: begin frame_q[0][7:4] = 4'd6; set_csum(ihl * 4, 1'b0); end
            7: begin frame_q[2] = 8'd0; frame_q[3] = 8'(ihl * 4 - 1); set_csum(ihl * 4, 1'b0); end
            default: ;
         endcase
         cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, frame_q.size())) : -1;
         run($sformatf("rnd%0d", t), ($urandom_range(0, 7) == 0), cut, 1'($urandom_range(0, 1)));
      end

      // Reset mid-payload: outputs clear at once and no eof is produced
      build(6, 20, 0, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'h30);
      while (frame_q.size() > 32) void'(frame_q.pop_back());
      a0 = a_eofs;
      b0 = b_eofs;
      send(1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1 check_zero("t6_midreset");
      repeat (2) @(posedge clk);
      check({"t6_midreset a_no_eof"}, 64'(a_eofs - a0), 64'd0);
      check({"t6_midreset b_no_eof"}, 64'(b_eofs - b0), 64'd0);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      build(5, 16, 0, 8'd17, LOCAL_IP, 8'h00, 1'b0, 1'b1, 8'h00);
      run("t6_after_reset", 1'b0, -1, 1'b0);

      check("a err_without_eof", 64'(a_err_noeof), 64'd0);
      check("b err_without_eof", 64'(b_err_noeof), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
